hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the stall/flush statistics counters.
REQ-002 SHALL have parameter REG_W, default 5, register-specifier width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port if_id_valid  input  1  IF/ID holds a real instruction.
REQ-006 SHALL have port id_opcode  input  6  opcode of the instruction in ID.
REQ-007 SHALL have ports id_rs, id_rt, id_rd  input  REG_W each  register fields of the instruction in ID.
REQ-008 SHALL have port branch_taken  input  1  branch or jump resolved taken in EX this cycle.
REQ-009 SHALL have port NoOp  output  1  bubble request driven into the control unit's NoOp input.
REQ-010 SHALL have ports pc_write, if_id_write  output  1 each  PC and IF/ID load enables.
REQ-011 SHALL have port if_id_flush  output  1  clear IF/ID to a bubble.
REQ-012 SHALL have ports stall_cnt, flush_cnt  output  CNT_W each  statistics, present only under REQ-030.

Function
REQ-013 SHALL keep a two-entry shadow pipeline (EX, MEM), each entry {valid, mem_read, reg_write, dst}.
REQ-014 SHALL decode the ID instruction as: lw 6'b100011 (mem_read=1, reg_write=1, dst=id_rt); R-type 6'b000000 (reg_write=1, dst=id_rd); sw 6'b101011, beq 6'b000100, bne 6'b000101, j 6'b000010 (reg_write=0); any other opcode = no write.
REQ-015 SHALL treat id_rt as a source only for R-type, sw, beq, bne; id_rs as a source for all except j.
REQ-016 SHALL flag load_use when EX.valid & EX.mem_read & EX.dst != 0 & (EX.dst == id_rs, or EX.dst == id_rt with rt used) & if_id_valid.
REQ-017 SHALL implement FSM states RUN and STALL.
REQ-018 In RUN with load_use and no branch_taken: NoOp=1, pc_write=0, if_id_write=0, next state STALL.
REQ-019 In STALL: load_use ignored, NoOp=0, pc_write=1, if_id_write=1, next state RUN; stall length exactly one cycle.
REQ-020 On branch_taken in any state: if_id_flush=1, NoOp=1, pc_write=1, if_id_write=1, next state RUN; branch_taken has priority over load_use.
REQ-021 With no hazard: NoOp=0, pc_write=1, if_id_write=1, if_id_flush=0.
REQ-022 Outputs NoOp, pc_write, if_id_write, if_id_flush SHALL be combinational from state, shadow EX and ID inputs (zero latency).
REQ-023 Each cycle MEM <= EX; EX <= bubble (all zero) if NoOp or !if_id_valid, else the decoded ID entry.
REQ-024 Writes to register 0 SHALL never cause a stall.

Reset
REQ-025 While rst=0: state=RUN, both shadow entries cleared, counters 0.
REQ-026 During reset outputs SHALL read NoOp=0, pc_write=1, if_id_write=1, if_id_flush=0.
REQ-027 Reset asserted mid-STALL SHALL abort the stall; first cycle after release is RUN with empty shadow.

Configuration
REQ-028 Macro HAZARD_STATS_EN selects statistics.
REQ-029 Without HAZARD_STATS_EN: no counters, stall_cnt/flush_cnt ports absent.
REQ-030 With HAZARD_STATS_EN: stall_cnt +1 per cycle REQ-018 fires, flush_cnt +1 per cycle branch_taken=1; both saturate at all-ones.

Structure
REQ-031 Opcode constants (R-type, lw, sw, beq, bne, j) and the shadow-entry typedef SHALL live in shared package mips_pkg, also used by the control unit.
REQ-032 SHALL instantiate one sub-module hazard_decode (combinational opcode -> {mem_read, reg_write, dst, uses_rs, uses_rt}).

Verification
REQ-033 lw $2 (rt=2), then add rs=2,rt=3 -> one cycle NoOp=1, pc_write=0, if_id_write=0; next cycle all clear.
REQ-034 lw $0, then add rs=0 -> no stall, NoOp=0 throughout.
REQ-035 lw $5 then beq rs=1,rt=5 with branch_taken=1 same cycle -> if_id_flush=1, NoOp=1, pc_write=1, state RUN, no stall.
REQ-036 lw $4, then j (rs field=4) -> no stall.
REQ-037 rst=0 during STALL cycle -> outputs return to REQ-026 values immediately; after release add rs=4 does not stall.
REQ-038 HAZARD_STATS_EN with CNT_W=2: five load-use stalls -> stall_cnt reads 3 and holds.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, shadow-pipeline entry, hazard FSM states.
// Used by the hazard unit and the control unit.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // Widest register specifier a shadow entry can hold; narrower ones zero-extend.
    localparam int REG_MAX = 8;

    localparam int SH_EX  = 0;
    localparam int SH_MEM = 1;

    typedef struct packed {
        logic               valid;
        logic               mem_read;
        logic               reg_write;
        logic [REG_MAX-1:0] dst;
    } shadow_t;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_decode.sv
// Opcode decode for hazard detection: destination register and which
// register fields the instruction reads.
module hazard_decode
    import mips_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [5:0]       opcode,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    output logic             mem_read,
    output logic             reg_write,
    output logic [REG_W-1:0] dst,
    output logic             uses_rs,
    output logic             uses_rt
);

    logic unused_rs;
    assign unused_rs = ^rs;

    always_comb begin
        mem_read  = 1'b0;
        reg_write = 1'b0;
        dst       = '0;
        uses_rs   = 1'b1;
        uses_rt   = 1'b0;
        unique case (1'b1)
            (opcode == OP_LW): begin
                mem_read  = 1'b1;
                reg_write = 1'b1;
                dst       = rt;
            end
            (opcode == OP_RTYPE): begin
                reg_write = 1'b1;
                dst       = rd;
                uses_rt   = 1'b1;
            end
            (opcode == OP_SW),
            (opcode == OP_BEQ),
            (opcode == OP_BNE): begin
                uses_rt = 1'b1;
            end
            (opcode == OP_J): begin
                uses_rs = 1'b0;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall / branch flush controller with an EX/MEM shadow pipeline.
// Define HAZARD_STATS_EN to add saturating stall_cnt / flush_cnt statistics.
module hazard_unit
    import mips_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_id_valid,
    input  logic [5:0]       id_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             branch_taken,
    output logic             NoOp,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    if (REG_W < 1 || REG_W > REG_MAX || CNT_W < 1) begin : g_param_check
        $error("hazard_unit: unsupported REG_W/CNT_W");
    end

    hz_state_t  state;
    hz_state_t  state_next;
    shadow_t    shadow_q [SH_EX:SH_MEM];
    shadow_t    ex_next;
    shadow_t    ex;

    logic             dec_mem_read;
    logic             dec_reg_write;
    logic [REG_W-1:0] dec_dst;
    logic             dec_uses_rs;
    logic             dec_uses_rt;
    logic             load_use;
    logic             stall_fire;

    hazard_decode #(
        .REG_W(REG_W)
    ) u_decode (
        .opcode   (id_opcode),
        .rs       (id_rs),
        .rt       (id_rt),
        .rd       (id_rd),
        .mem_read (dec_mem_read),
        .reg_write(dec_reg_write),
        .dst      (dec_dst),
        .uses_rs  (dec_uses_rs),
        .uses_rt  (dec_uses_rt)
    );

    assign ex = shadow_q[SH_EX];

    // A load into $0 never produces a value anyone waits on.
    always_comb begin
        load_use = if_id_valid && ex.valid && ex.mem_read
                && (ex.dst != '0)
                && ((dec_uses_rs && ex.dst == REG_MAX'(id_rs))
                 || (dec_uses_rt && ex.dst == REG_MAX'(id_rt)));
    end

    always_comb begin
        NoOp        = 1'b0;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        stall_fire  = 1'b0;
        state_next  = ST_RUN;
        if (rst) begin
            if (branch_taken) begin
                NoOp        = 1'b1;
                if_id_flush = 1'b1;
            end else if (state == ST_RUN && load_use) begin
                NoOp        = 1'b1;
                pc_write    = 1'b0;
                if_id_write = 1'b0;
                stall_fire  = 1'b1;
                state_next  = ST_STALL;
            end
        end
    end

    always_comb begin
        ex_next = '0;
        if (!NoOp && if_id_valid) begin
            ex_next.valid     = 1'b1;
            ex_next.mem_read  = dec_mem_read;
            ex_next.reg_write = dec_reg_write;
            ex_next.dst       = REG_MAX'(dec_dst);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= ST_RUN;
            shadow_q[SH_EX]  <= '0;
            shadow_q[SH_MEM] <= '0;
        end else begin
            state            <= state_next;
            shadow_q[SH_EX]  <= ex_next;
            shadow_q[SH_MEM] <= shadow_q[SH_EX];
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_fire && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if (branch_taken && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_stats;
    assign unused_stats = stall_fire;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed vector bench for hazard_unit; define HAZARD_STATS_EN to also
// check the saturating statistics counters (built with CNT_W=2).
module tb_hazard_unit;

    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] J   = 6'b000010;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] ADI = 6'b001000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       if_id_valid = 1'b0;
    logic [5:0] id_opcode = '0;
    logic [4:0] id_rs = '0;
    logic [4:0] id_rt = '0;
    logic [4:0] id_rd = '0;
    logic       branch_taken = 1'b0;
    logic       NoOp;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

`ifdef HAZARD_STATS_EN
    logic [1:0] stall_cnt;
    logic [1:0] flush_cnt;

    hazard_unit #(.CNT_W(2), .REG_W(5)) dut (
        .clk(clk), .rst(rst), .if_id_valid(if_id_valid),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .branch_taken(branch_taken),
        .NoOp(NoOp), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );
`else
    hazard_unit #(.CNT_W(16), .REG_W(5)) dut (
        .clk(clk), .rst(rst), .if_id_valid(if_id_valid),
        .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .branch_taken(branch_taken),
        .NoOp(NoOp), .pc_write(pc_write),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush)
    );
`endif

    typedef struct {
        logic       v;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       br;
        logic [3:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic v, input logic [5:0] op,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic br,
                                input logic [3:0] exp);
        vec_t t;
        t.v = v; t.op = op; t.rs = rs; t.rt = rt; t.rd = rd;
        t.br = br; t.exp = exp;
        return t;
    endfunction

    // exp = {NoOp, pc_write, if_id_write, if_id_flush}
    localparam logic [3:0] CLR   = 4'b0110;
    localparam logic [3:0] STALL = 4'b1000;
    localparam logic [3:0] FLUSH = 4'b1111;

    task automatic drive(input vec_t t);
        if_id_valid  = t.v;
        id_opcode    = t.op;
        id_rs        = t.rs;
        id_rt        = t.rt;
        id_rd        = t.rd;
        branch_taken = t.br;
    endtask

    task automatic check(input string nm, input logic [3:0] exp);
        logic [3:0] act;
        act = {NoOp, pc_write, if_id_write, if_id_flush};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {NoOp,pcw,ifw,flush}=%b want %b",
                     nm, act, exp);
        end
    endtask

    // Inputs applied at posedge+1, outputs sampled at posedge+4.
    task automatic cycle(input vec_t t, input string nm);
        drive(t);
        #3;
        check(nm, t.exp);
        @(posedge clk);
        #1;
    endtask

`ifdef HAZARD_STATS_EN
    task automatic check_cnt(input string nm, input logic [1:0] act,
                             input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask
`endif

    initial begin
        tbl.push_back(mk(1, LW,  1, 2, 0, 0, CLR));
        tbl.push_back(mk(1, RT,  2, 3, 4, 0, STALL));
        tbl.push_back(mk(1, RT,  2, 3, 4, 0, CLR));
        tbl.push_back(mk(1, RT,  4, 4, 6, 0, CLR));
        tbl.push_back(mk(1, LW,  1, 0, 0, 0, CLR));
        tbl.push_back(mk(1, RT,  0, 0, 7, 0, CLR));
        tbl.push_back(mk(1, LW,  1, 5, 0, 0, CLR));
        tbl.push_back(mk(1, BEQ, 1, 5, 0, 1, FLUSH));
        tbl.push_back(mk(1, RT,  5, 5, 1, 0, CLR));
        tbl.push_back(mk(1, LW,  2, 4, 0, 0, CLR));
        tbl.push_back(mk(1, J,   4, 4, 0, 0, CLR));
        tbl.push_back(mk(1, LW,  0, 3, 0, 0, CLR));
        tbl.push_back(mk(1, SW,  1, 3, 0, 0, STALL));
        tbl.push_back(mk(1, SW,  1, 3, 0, 0, CLR));
        tbl.push_back(mk(1, LW,  1, 6, 0, 0, CLR));
        tbl.push_back(mk(0, RT,  6, 6, 2, 0, CLR));
        tbl.push_back(mk(1, LW,  0, 7, 0, 0, CLR));
        tbl.push_back(mk(1, LW,  7, 1, 0, 0, STALL));
        tbl.push_back(mk(1, LW,  7, 1, 0, 0, CLR));
        tbl.push_back(mk(1, ADI, 9, 1, 0, 0, CLR));
        tbl.push_back(mk(1, LW,  0, 2, 0, 0, CLR));
        tbl.push_back(mk(1, BNE, 3, 2, 0, 0, STALL));
        tbl.push_back(mk(1, BNE, 3, 2, 0, 1, FLUSH));
        tbl.push_back(mk(1, RT,  2, 2, 3, 0, CLR));

        // Reset: branch_taken must not leak through while rst is low.
        rst = 1'b0;
        drive(mk(1, RT, 0, 0, 0, 1, CLR));
        #3;
        check("reset_outputs", CLR);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
`ifdef HAZARD_STATS_EN
        check_cnt("reset_stall_cnt", stall_cnt, 2'd0);
        check_cnt("reset_flush_cnt", flush_cnt, 2'd0);
`endif

        foreach (tbl[i]) cycle(tbl[i], $sformatf("vec%0d", i));

        // Reset asserted in the STALL cycle aborts the stall.
        cycle(mk(1, LW, 1, 4, 0, 0, CLR), "rst_lw");
        cycle(mk(1, RT, 4, 4, 5, 0, STALL), "rst_stall");
        drive(mk(1, RT, 4, 4, 5, 1, CLR));
        rst = 1'b0;
        #3;
        check("rst_mid_stall", CLR);
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(mk(1, RT, 4, 4, 5, 0, CLR), "post_rst_add");

`ifdef HAZARD_STATS_EN
        rst = 1'b0;
        #3;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle(mk(1, LW, 1, 2, 0, 0, CLR), "sat_lw");
            cycle(mk(1, RT, 2, 3, 4, 0, STALL), "sat_stall");
            cycle(mk(1, RT, 2, 3, 4, 0, CLR), "sat_resume");
        end
        check_cnt("stall_cnt_sat", stall_cnt, 2'd3);
        check_cnt("flush_cnt_idle", flush_cnt, 2'd0);
        cycle(mk(1, RT, 1, 1, 1, 1, FLUSH), "sat_flush");
        check_cnt("flush_cnt_one", flush_cnt, 2'd1);
        check_cnt("stall_cnt_hold", stall_cnt, 2'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
